gpio_pad_ctrl: RTL and testbench

GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

---
 rtl/gpio_pad_ctrl.sv | 135 +++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_pad_ctrl
//  Brief    : 32-bit GPIO controller. Holds the output/enable registers,
//             synchronizes the pad inputs, detects edges per bit and keeps
//             sticky (W1C) interrupt status.
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_pad_ctrl (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic [31:0] io_pad_i,
  output logic [31:0] io_pad_o,
  output logic [31:0] io_pad_oe,
  output logic        irq_o
);

  localparam logic [2:0] ADDR_IN    = 3'd0;
  localparam logic [2:0] ADDR_OUT   = 3'd1;
  localparam logic [2:0] ADDR_OE    = 3'd2;
  localparam logic [2:0] ADDR_INTE  = 3'd3;
  localparam logic [2:0] ADDR_PTRIG = 3'd4;
  localparam logic [2:0] ADDR_INTS  = 3'd5;
  localparam logic [2:0] ADDR_CTRL  = 3'd6;

  // Detection is armed once the synchronizer and history flops hold real
  // pad samples rather than reset zeros.
  localparam logic [1:0] WARM_DONE  = 2'd3;

  // Software-visible registers
  logic [31:0] out_q,   out_d;
  logic [31:0] oe_q,    oe_d;
  logic [31:0] inte_q,  inte_d;
  logic [31:0] ptrig_q, ptrig_d;
  logic [31:0] ints_q,  ints_d;
  logic        inte_g_q, inte_g_d;

  // Input path: two synchronizer stages plus one history stage
  logic [31:0] s1_q;
  logic [31:0] s2_q;
  logic [31:0] h_q;
  logic [1:0]  warm_q;

  logic        warm_ok;
  logic [31:0] rise_vec;
  logic [31:0] fall_vec;
  logic [31:0] event_vec;
  logic [31:0] ints_clr;
  logic [31:0] rd_mux;

  assign warm_ok   = (warm_q == WARM_DONE);
  assign rise_vec  = ~h_q &  s2_q;
  assign fall_vec  =  h_q & ~s2_q;
  assign event_vec = inte_q & ((ptrig_q & rise_vec) | (~ptrig_q & fall_vec))
                     & {32{warm_ok}};

  // Register write decode and sticky status update (event set wins over W1C)
  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    inte_d   = inte_q;
    ptrig_d  = ptrig_q;
    inte_g_d = inte_g_q;
    ints_clr = '0;
    if (reg_wr) begin
      case (reg_addr)
        ADDR_OUT:   out_d    = reg_wdata;
        ADDR_OE:    oe_d     = reg_wdata;
        ADDR_INTE:  inte_d   = reg_wdata;
        ADDR_PTRIG: ptrig_d  = reg_wdata;
        ADDR_INTS:  ints_clr = reg_wdata;
        ADDR_CTRL:  inte_g_d = reg_wdata[0];
        default:    ;
      endcase
    end
    ints_d = (ints_q & ~ints_clr) | event_vec;
  end

  // All state: register file, synchronizer/history chain and warm-up counter
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      out_q    <= '0;
      oe_q     <= '0;
      inte_q   <= '0;
      ptrig_q  <= '0;
      ints_q   <= '0;
      inte_g_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      h_q      <= '0;
      warm_q   <= '0;
    end else begin
      out_q    <= out_d;
      oe_q     <= oe_d;
      inte_q   <= inte_d;
      ptrig_q  <= ptrig_d;
      ints_q   <= ints_d;
      inte_g_q <= inte_g_d;
      s1_q     <= io_pad_i;
      s2_q     <= s1_q;
      h_q      <= s2_q;
      if (warm_q != WARM_DONE) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  // Read mux straight from current register state, so a same-cycle write
  // still returns the old value
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_IN:    rd_mux = s2_q;
      ADDR_OUT:   rd_mux = out_q;
      ADDR_OE:    rd_mux = oe_q;
      ADDR_INTE:  rd_mux = inte_q;
      ADDR_PTRIG: rd_mux = ptrig_q;
      ADDR_INTS:  rd_mux = ints_q;
      ADDR_CTRL:  rd_mux = {30'd0, |ints_q, inte_g_q};
      default:    rd_mux = '0;
    endcase
    reg_rdata = reg_rd ? rd_mux : 32'd0;
  end

  assign io_pad_o  = out_q;
  assign io_pad_oe = oe_q;
  assign irq_o     = inte_g_q & (|ints_q);

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_pad_ctrl
//  Brief    : Self-checking bench for gpio_pad_ctrl: directed scenarios
//             followed by randomized register/pad traffic, compared each
//             cycle against a sample-history reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_pad_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic [31:0] io_pad_i;
  logic [31:0] io_pad_o;
  logic [31:0] io_pad_oe;
  logic        irq_o;

  int checks   = 0;
  int failures = 0;

  gpio_pad_ctrl dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .io_pad_i  (io_pad_i),
    .io_pad_o  (io_pad_o),
    .io_pad_oe (io_pad_oe),
    .irq_o     (irq_o)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: register contents plus the list of pad samples taken
  // at recent edges (index 0 = newest), and edges elapsed since reset.
  logic [31:0] m_out, m_oe, m_inte, m_ptrig, m_ints;
  logic        m_ge;
  logic [31:0] samp[$];
  int          m_age;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return samp[1];
      3'd1:    return m_out;
      3'd2:    return m_oe;
      3'd3:    return m_inte;
      3'd4:    return m_ptrig;
      3'd5:    return m_ints;
      3'd6:    return {30'd0, (m_ints != 0), m_ge};
      default: return 32'd0;
    endcase
  endfunction

  // Apply one rising edge to the model using the inputs present at the edge
  task automatic model_edge();
    logic [31:0] evt;
    logic [31:0] clr;
    logic        prev, cur;
    if (!PRESETn) begin
      m_out = 0; m_oe = 0; m_inte = 0; m_ptrig = 0; m_ints = 0; m_ge = 0;
      samp = {32'd0, 32'd0, 32'd0};
      m_age = 0;
    end else begin
      evt = 0;
      clr = 0;
      // samp[1] is the value two edges old, samp[2] the one before it
      if (m_age >= 3) begin
        for (int i = 0; i < 32; i++) begin
          prev = samp[2][i];
          cur  = samp[1][i];
          if (m_inte[i] && (m_ptrig[i] ? (!prev && cur) : (prev && !cur)))
            evt[i] = 1'b1;
        end
      end
      if (reg_wr) begin
        case (reg_addr)
          3'd1: m_out   = reg_wdata;
          3'd2: m_oe    = reg_wdata;
          3'd3: m_inte  = reg_wdata;
          3'd4: m_ptrig = reg_wdata;
          3'd5: clr     = reg_wdata;
          3'd6: m_ge    = reg_wdata[0];
          default: ;
        endcase
      end
      m_ints = (m_ints & ~clr) | evt;
      samp.push_front(io_pad_i);
      void'(samp.pop_back());
      m_age++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, then clock DUT and model
  task automatic cyc();
    #3;
    check("pad_o",  io_pad_o,  m_out);
    check("pad_oe", io_pad_oe, m_oe);
    check("irq",    {31'd0, irq_o}, {31'd0, m_ge & (m_ints != 0)});
    check("rdata",  reg_rdata, reg_rd ? m_read(reg_addr) : 32'd0);
    @(posedge PCLK);
    model_edge();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    cyc();
    reg_wr = 1'b0;
  endtask

  task automatic expect_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    reg_rd = 1'b1; reg_addr = a;
    #2;
    check(tag, reg_rdata, exp);
    cyc();
    reg_rd = 1'b0;
  endtask

  task automatic expect_irq(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, irq_o}, {31'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; reg_wr = 0; reg_rd = 0; reg_addr = 0; reg_wdata = 0;
    io_pad_i = $urandom;
    samp = {32'd0, 32'd0, 32'd0};
    @(posedge PCLK);
    model_edge();
    #1;
    cyc();
    // Reset state
    reg_rd = 1'b1; reg_addr = 3'd1;
    #2;
    check("rst_rdata", reg_rdata, 32'd0);
    check("rst_pad_o", io_pad_o, 32'd0);
    check("rst_oe",    io_pad_oe, 32'd0);
    check("rst_irq",   {31'd0, irq_o}, 32'd0);
    cyc();
    reg_rd = 1'b0;
    PRESETn = 1'b1;
    io_pad_i = 32'd0;
    cycles(5);

    // Output and enable registers
    wr(3'd2, 32'h0000FFFF);
    wr(3'd1, 32'hA5A5A5A5);
    #1;
    check("oe_val",  io_pad_oe, 32'h0000FFFF);
    check("out_val", io_pad_o,  32'hA5A5A5A5);
    expect_rd("rd_out", 3'd1, 32'hA5A5A5A5);

    // Rising edge on bit 0
    wr(3'd3, 32'h1);
    wr(3'd4, 32'h1);
    wr(3'd6, 32'h1);
    io_pad_i = 32'h1;
    cyc();                                   // edge k
    cyc();                                   // edge k+1
    expect_rd("in_bit0", 3'd0, 32'h1);       // includes edge k+2
    expect_rd("ints_rise", 3'd5, 32'h1);
    expect_irq("irq_set", 1'b1);
    wr(3'd5, 32'h1);
    expect_irq("irq_clr", 1'b0);

    // Falling-edge trigger on bit 3; rising edge on it must be ignored
    wr(3'd3, 32'h9);
    io_pad_i = 32'h9;
    cycles(5);
    expect_rd("no_rise_b3", 3'd5, 32'h0);
    io_pad_i = 32'h1;
    cycles(4);
    expect_rd("fall_b3", 3'd5, 32'h8);
    io_pad_i = 32'h9;
    cycles(4);
    expect_rd("rise_b3_ign", 3'd5, 32'h8);
    wr(3'd5, 32'h8);

    // W1C colliding with a fresh event on bit 0: set wins
    io_pad_i = 32'h8;
    cycles(4);
    io_pad_i = 32'h9;
    cyc();
    cyc();
    wr(3'd5, 32'h1);
    expect_rd("set_wins", 3'd5, 32'h1);

    // Clearing INTE leaves the pending status
    wr(3'd3, 32'h0);
    expect_rd("inte_keep", 3'd5, 32'h1);

    // Pad held high through reset must not raise events
    io_pad_i = 32'hFFFFFFFF;
    PRESETn = 1'b0;
    cycles(2);
    PRESETn = 1'b1;
    wr(3'd3, 32'hFFFFFFFF);
    wr(3'd4, 32'hFFFFFFFF);
    cycles(5);
    expect_rd("warm_ints", 3'd5, 32'h0);
    expect_rd("warm_in",   3'd0, 32'hFFFFFFFF);

    // Build INTS=0x5, then reset with a concurrent W1C
    io_pad_i = 32'h0;
    cycles(4);
    wr(3'd3, 32'h5);
    wr(3'd6, 32'h1);
    io_pad_i = 32'h5;
    cycles(4);
    expect_rd("ints_5", 3'd5, 32'h5);
    expect_irq("irq_5", 1'b1);
    PRESETn = 1'b0;
    wr(3'd5, 32'h5);
    PRESETn = 1'b1;
    expect_irq("irq_rst", 1'b0);
    for (int a = 1; a < 8; a++) expect_rd("post_rst", a[2:0], 32'd0);

    // Randomized traffic, including occasional resets and pad loopback
    for (int n = 0; n < 400; n++) begin
      PRESETn   = ($urandom_range(0, 59) != 0);
      reg_wr    = ($urandom_range(0, 2) == 0);
      reg_rd    = ($urandom_range(0, 1) == 0);
      reg_addr  = 3'($urandom_range(0, 7));
      reg_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) io_pad_i = $urandom;
      else if ($urandom_range(0, 1) == 0) io_pad_i = (io_pad_i & ~io_pad_oe) | (io_pad_o & io_pad_oe);
      cyc();
    end
    PRESETn = 1'b1; reg_wr = 0; reg_rd = 0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
